// File: rtl/branch_cmp_pipe_if.sv
// rtl/branch_cmp_pipe_if.sv - request/response bundle for branch_cmp_pipe
// slave is the comparator side, master is the issue/redirect side.
interface branch_cmp_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1_d;
  logic [XLEN-1:0]  rs2_d;
  logic [2:0]       cmp_op;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic             b;
  logic [XLEN-1:0]  target;
  logic             mispredict;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, rs1_d, rs2_d, cmp_op, pc, imm, pred_taken, tag, out_ready,
    output in_ready, out_valid, b, target, mispredict, illegal, out_tag
  );

  modport master (
    output in_valid, rs1_d, rs2_d, cmp_op, pc, imm, pred_taken, tag, out_ready,
    input  in_ready, out_valid, b, target, mispredict, illegal, out_tag
  );
endinterface

// File: rtl/branch_cmp_pipe.sv
// rtl/branch_cmp_pipe.sv - two-stage RV32I branch comparator with valid/ready and flush
// Optional statistics counters are built when CMP_STATS_EN is defined.
module branch_cmp_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  branch_cmp_pipe_if.slave bus
`ifdef CMP_STATS_EN
  ,
  output logic [31:0] cnt_cmp,
  output logic [31:0] cnt_taken,
  output logic [31:0] cnt_mispred
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
  logic [XLEN-1:0]  s1_rs2_q, s1_rs2_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
  logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
  logic             s1_pred_q, s1_pred_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_b_q, s2_b_d;
  logic [XLEN-1:0]  s2_target_q, s2_target_d;
  logic             s2_mispred_q, s2_mispred_d;
  logic             s2_illegal_q, s2_illegal_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic s2_load;
  logic in_ready_c;
  logic accept;
  logic op_eq, op_lt_s, op_lt_u;
  logic cmp_b, cmp_illegal;

  assign op_eq   = (s1_rs1_q == s1_rs2_q);
  assign op_lt_s = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
  assign op_lt_u = (s1_rs1_q < s1_rs2_q);

  always_comb begin
    cmp_b       = 1'b0;
    cmp_illegal = 1'b0;
    case (s1_op_q)
      3'd0:    cmp_b = op_eq;
      3'd1:    cmp_b = !op_eq;
      3'd2:    cmp_b = op_lt_s;
      3'd3:    cmp_b = !op_lt_s;
      3'd4:    cmp_b = op_lt_u;
      3'd5:    cmp_b = !op_lt_u;
      default: cmp_illegal = 1'b1;
    endcase
  end

  // in_ready looks through S2 at out_ready so a draining pipe keeps full rate.
  assign s2_load    = s1_valid_q & (!s2_valid_q | bus.out_ready);
  assign in_ready_c = rst_n & !flush & (!s1_valid_q | s2_load);
  assign accept     = bus.in_valid & in_ready_c;

  always_comb begin
    s1_rs1_d     = s1_rs1_q;
    s1_rs2_d     = s1_rs2_q;
    s1_op_d      = s1_op_q;
    s1_pc_d      = s1_pc_q;
    s1_imm_d     = s1_imm_q;
    s1_pred_d    = s1_pred_q;
    s1_tag_d     = s1_tag_q;
    s2_b_d       = s2_b_q;
    s2_target_d  = s2_target_q;
    s2_mispred_d = s2_mispred_q;
    s2_illegal_d = s2_illegal_q;
    s2_tag_d     = s2_tag_q;

    if (accept) begin
      s1_rs1_d  = bus.rs1_d;
      s1_rs2_d  = bus.rs2_d;
      s1_op_d   = bus.cmp_op;
      s1_pc_d   = bus.pc;
      s1_imm_d  = bus.imm;
      s1_pred_d = bus.pred_taken;
      s1_tag_d  = bus.tag;
    end

    if (s2_load && !flush) begin
      s2_b_d       = cmp_b;
      s2_target_d  = s1_pc_q + s1_imm_q;
      s2_mispred_d = cmp_b ^ s1_pred_q;
      s2_illegal_d = cmp_illegal;
      s2_tag_d     = s1_tag_q;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
      s2_valid_d = s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
    end
  end

`ifdef CMP_STATS_EN
  logic        out_hs;
  logic [31:0] cnt_cmp_q, cnt_cmp_d;
  logic [31:0] cnt_taken_q, cnt_taken_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  assign out_hs = s2_valid_q & bus.out_ready;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt_cmp_d     = cnt_cmp_q;
    cnt_taken_d   = cnt_taken_q;
    cnt_mispred_d = cnt_mispred_q;
    if (out_hs) begin
      if (cnt_cmp_q != 32'hFFFF_FFFF)
        cnt_cmp_d = cnt_cmp_q + 32'd1;
      if (s2_b_q && cnt_taken_q != 32'hFFFF_FFFF)
        cnt_taken_d = cnt_taken_q + 32'd1;
      if (s2_mispred_q && cnt_mispred_q != 32'hFFFF_FFFF)
        cnt_mispred_d = cnt_mispred_q + 32'd1;
    end
  end

  assign cnt_cmp     = cnt_cmp_q;
  assign cnt_taken   = cnt_taken_q;
  assign cnt_mispred = cnt_mispred_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_rs1_q     <= '0;
      s1_rs2_q     <= '0;
      s1_op_q      <= '0;
      s1_pc_q      <= '0;
      s1_imm_q     <= '0;
      s1_pred_q    <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_b_q       <= 1'b0;
      s2_target_q  <= '0;
      s2_mispred_q <= 1'b0;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
`ifdef CMP_STATS_EN
      cnt_cmp_q     <= '0;
      cnt_taken_q   <= '0;
      cnt_mispred_q <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_rs1_q     <= s1_rs1_d;
      s1_rs2_q     <= s1_rs2_d;
      s1_op_q      <= s1_op_d;
      s1_pc_q      <= s1_pc_d;
      s1_imm_q     <= s1_imm_d;
      s1_pred_q    <= s1_pred_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_b_q       <= s2_b_d;
      s2_target_q  <= s2_target_d;
      s2_mispred_q <= s2_mispred_d;
      s2_illegal_q <= s2_illegal_d;
      s2_tag_q     <= s2_tag_d;
`ifdef CMP_STATS_EN
      cnt_cmp_q     <= cnt_cmp_d;
      cnt_taken_q   <= cnt_taken_d;
      cnt_mispred_q <= cnt_mispred_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = s2_valid_q;
  assign bus.b          = s2_b_q;
  assign bus.target     = s2_target_q;
  assign bus.mispredict = s2_mispred_q;
  assign bus.illegal    = s2_illegal_q;
  assign bus.out_tag    = s2_tag_q;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb/tb_branch_cmp_pipe.sv - scoreboard bench for branch_cmp_pipe
// Directed steps push expected results; a negedge monitor pops them on each output handshake.
module tb_branch_cmp_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rnd_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_cmp_pipe_if #(.XLEN(32), .TAG_W(4)) bus ();

`ifdef CMP_STATS_EN
  logic [31:0] cnt_cmp, cnt_taken, cnt_mispred;
`endif

  branch_cmp_pipe #(.XLEN(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef CMP_STATS_EN
    ,
    .cnt_cmp     (cnt_cmp),
    .cnt_taken   (cnt_taken),
    .cnt_mispred (cnt_mispred)
`endif
  );

  typedef struct {
    logic        b;
    logic [31:0] target;
    logic        mis;
    logic        ill;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic ref_b(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c);
    case (op)
      3'd0:    return a == c;
      3'd1:    return a != c;
      3'd2:    return $signed(a) < $signed(c);
      3'd3:    return !($signed(a) < $signed(c));
      3'd4:    return a < c;
      3'd5:    return !(a < c);
      default: return 1'b0;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                      input logic [31:0] p, input logic [31:0] im, input logic pr,
                      input logic [3:0] tg, input logic eb, input bit lat);
    exp_t e;
    int   n;
    bus.in_valid   = 1'b1;
    bus.cmp_op     = op;
    bus.rs1_d      = a;
    bus.rs2_d      = c;
    bus.pc         = p;
    bus.imm        = im;
    bus.pred_taken = pr;
    bus.tag        = tg;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.in_ready !== 1'b1 && n < 200);
    chk("accept", 32'(bus.in_ready), 32'd1);
    e.b      = eb;
    e.target = p + im;
    e.mis    = eb ^ pr;
    e.ill    = (op >= 3'd6);
    e.tag    = tg;
    e.acc    = cyc;
    e.lat    = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_b", 32'(bus.b), 32'd0);
    chk("rst_target", bus.target, 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef CMP_STATS_EN
    chk("rst_cnt_cmp", cnt_cmp, 32'd0);
    chk("rst_cnt_taken", cnt_taken, 32'd0);
    chk("rst_cnt_mispred", cnt_mispred, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL spurious_output: observed tag %h expected no output", bus.out_tag);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
        chk("b", 32'(bus.b), 32'(mon_e.b));
        chk("target", bus.target, mon_e.target);
        chk("mispredict", 32'(bus.mispredict), 32'(mon_e.mis));
        chk("illegal", 32'(bus.illegal), 32'(mon_e.ill));
        if (mon_e.lat)
          chk("latency", 32'(cyc), 32'(mon_e.acc + 2));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.cmp_op = '0;
    bus.rs1_d = '0;
    bus.rs2_d = '0;
    bus.pc = '0;
    bus.imm = '0;
    bus.pred_taken = 1'b0;
    bus.tag = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Sign handling, back to back, with exact latency
    send(3'd2, 32'hFFFF_FFFC, 32'd3, 32'h100, 32'h20, 1'b0, 4'h1, 1'b1, 1'b1);
    send(3'd4, 32'hFFFF_FFFC, 32'd3, 32'h104, 32'h20, 1'b0, 4'h2, 1'b0, 1'b1);
    send(3'd3, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h108, 32'h20, 1'b1, 4'h3, 1'b1, 1'b1);
    send(3'd0, 32'd10, 32'd10, 32'h10C, 32'hFFFF_FFF0, 1'b1, 4'h4, 1'b1, 1'b1);
    send(3'd1, 32'd3, 32'd3, 32'h110, 32'h4, 1'b1, 4'h5, 1'b0, 1'b1);
    // Target wrap and mispredict
    send(3'd0, 32'd4, 32'd4, 32'hFFFF_FFF8, 32'h10, 1'b0, 4'h6, 1'b1, 1'b1);
    // Illegal op
    send(3'd7, 32'd5, 32'd5, 32'h200, 32'h8, 1'b1, 4'hA, 1'b0, 1'b1);
    drain();

    // Backpressure: tags 1,2 fill the pipe, tag 3 must wait
    bus.out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd1, 32'h1000, 32'h40, 1'b1, 4'h1, 1'b1, 1'b0);
    send(3'd1, 32'd1, 32'd1, 32'h2000, 32'h40, 1'b0, 4'h2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.cmp_op = 3'd5;
    bus.rs1_d = 32'd9;
    bus.rs2_d = 32'd2;
    bus.pc = 32'h3000;
    bus.imm = 32'h40;
    bus.pred_taken = 1'b1;
    bus.tag = 4'h3;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_tag", 32'(bus.out_tag), 32'd1);
      chk("hold_target", bus.target, 32'h1040);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'd5, 32'd9, 32'd2, 32'h3000, 32'h40, 1'b1, 4'h3, 1'b1, 1'b0);
    drain();

    // Flush with two in flight; input offered during flush is refused
    bus.out_ready = 1'b0;
    send(3'd0, 32'd7, 32'd7, 32'h400, 32'h4, 1'b0, 4'h7, 1'b1, 1'b0);
    send(3'd0, 32'd7, 32'd8, 32'h404, 32'h4, 1'b0, 4'h8, 1'b0, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.tag = 4'hF;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    send(3'd2, 32'd1, 32'd2, 32'h500, 32'h8, 1'b1, 4'h9, 1'b1, 1'b1);
    drain();

    // Reset mid-stream, together with flush
    bus.out_ready = 1'b0;
    send(3'd1, 32'd1, 32'd2, 32'h600, 32'h10, 1'b0, 4'hB, 1'b1, 1'b0);
    send(3'd4, 32'd1, 32'd2, 32'h604, 32'h10, 1'b0, 4'hC, 1'b1, 1'b0);
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    exp_q.delete();
    rst_n = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Five handshakes: three taken, two mispredicted
    send(3'd0, 32'd1, 32'd1, 32'h700, 32'h4, 1'b1, 4'h1, 1'b1, 1'b1);
    send(3'd1, 32'd1, 32'd2, 32'h704, 32'h4, 1'b0, 4'h2, 1'b1, 1'b1);
    send(3'd2, 32'd1, 32'd2, 32'h708, 32'h4, 1'b1, 4'h3, 1'b1, 1'b1);
    send(3'd5, 32'd1, 32'd2, 32'h70C, 32'h4, 1'b1, 4'h4, 1'b0, 1'b1);
    send(3'd0, 32'd1, 32'd2, 32'h710, 32'h4, 1'b0, 4'h5, 1'b0, 1'b1);
    drain();
`ifdef CMP_STATS_EN
    chk("cnt_cmp_5", cnt_cmp, 32'd5);
    chk("cnt_taken_3", cnt_taken, 32'd3);
    chk("cnt_mispred_2", cnt_mispred, 32'd2);
`endif
    bus.out_ready = 1'b0;
    send(3'd0, 32'd2, 32'd2, 32'h800, 32'h4, 1'b0, 4'h6, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
`ifdef CMP_STATS_EN
    chk("stall_cnt_cmp", cnt_cmp, 32'd5);
    chk("stall_cnt_taken", cnt_taken, 32'd3);
    chk("stall_cnt_mispred", cnt_mispred, 32'd2);
`endif
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
`ifdef CMP_STATS_EN
    chk("cnt_cmp_6", cnt_cmp, 32'd6);
    chk("cnt_taken_4", cnt_taken, 32'd4);
    chk("cnt_mispred_3", cnt_mispred, 32'd3);
`endif

    // Random ops under random backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, c;
      logic        pr;
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      c  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      pr = 1'($urandom_range(0, 1));
      send(op, a, c, $urandom(), $urandom(), pr, 4'(i), ref_b(op, a, c), 1'b0);
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
